// File: rtl/pio_logistic_sender_pkg.sv
// rtl/pio_logistic_sender_pkg.sv - request codes, response tags, Q4.28 constants and FSM states
package pio_sender_pkg;

  localparam logic [31:0] REQ_HI  = 32'h0000_0006;
  localparam logic [31:0] REQ_LO  = 32'h0000_0003;
  localparam logic [15:0] TAG_HI  = 16'h0045;
  localparam logic [15:0] TAG_LO  = 16'h0048;
  localparam logic [31:0] ONE_Q28 = 32'h1000_0000;

  typedef enum logic [2:0] {
    WAIT_HI = 3'd0,
    SEND_HI = 3'd1,
    WAIT_LO = 3'd2,
    SEND_LO = 3'd3,
    COMPUTE = 3'd4,
    DONE    = 3'd5
  } state_e;

  function automatic logic is_req(logic [31:0] code);
    return (code == REQ_HI) || (code == REQ_LO);
  endfunction

endpackage

// File: rtl/pio_logistic_sender_if.sv
// rtl/pio_logistic_sender_if.sv - PIO request/response pair between fill block and sender
interface pio_logistic_sender_if;
  logic [31:0] outputPio;
  logic [31:0] inputPio;

  modport master (output outputPio, input inputPio);
  modport slave  (input outputPio, output inputPio);
endinterface

// File: rtl/pio_logistic_sender_logistic_step.sv
// rtl/pio_logistic_sender_logistic_step.sv - two-stage registered Q4.28 logistic map step
module logistic_step
  import pio_sender_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] x_i,
  output logic [31:0] y_o,
  output logic        valid_o
);

  logic [29:0] x4_q;
  logic [28:0] omx_q;
  logic        s1_valid_q;
  logic [31:0] y_q;
  logic        valid_q;

  logic [31:0] omx_full;
  logic [63:0] prod;
  logic        step_unused;

  // ONE - x wraps mod 2^32 for out-of-range x; only the low 29 bits feed the multiply
  assign omx_full    = ONE_Q28 - x_i;
  assign prod        = {34'd0, x4_q} * {35'd0, omx_q};
  assign step_unused = ^{x_i[31:28], omx_full[31:29], prod[63:60], prod[27:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x4_q       <= '0;
      omx_q      <= '0;
      s1_valid_q <= 1'b0;
      y_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      s1_valid_q <= start_i;
      valid_q    <= s1_valid_q;
      if (start_i) begin
        x4_q  <= {x_i[27:0], 2'b00};
        omx_q <= omx_full[28:0];
      end
      if (s1_valid_q) begin
        y_q <= prod[59:28];
      end
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pio_logistic_sender.sv
// rtl/pio_logistic_sender.sv - answers fill-block half-word requests with tagged logistic-map words
module pio_logistic_sender
  import pio_sender_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'h03E4_4970,
  parameter int          NUM_WORDS = 512
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  pio_logistic_sender_if.slave       pio,
  output logic [9:0]                 word_count,
  output logic                       done,
  output logic                       proto_err
);

  localparam logic [9:0] NUM_W = NUM_WORDS[9:0];

  state_e      state_q;
  logic [31:0] req_q;
  logic [31:0] req_prev_q;
  logic [31:0] x_q;
  logic [31:0] pio_q;
  logic [9:0]  word_count_q;
  logic        done_q;
  logic        proto_err_q;
  logic        pend_valid_q;
  logic        pend_hi_q;

  logic        new_req;
  logic        new_is_hi;
  logic        have_req;
  logic        req_hi;
  logic        step_start;
  logic [31:0] step_y;
  logic        step_valid;

  assign new_req    = is_req(req_q) && (req_q != req_prev_q);
  assign new_is_hi  = (req_q == REQ_HI);
  // A request caught while busy takes priority at the next wait state
  assign have_req   = pend_valid_q || new_req;
  assign req_hi     = pend_valid_q ? pend_hi_q : new_is_hi;
  assign step_start = (state_q == SEND_LO);

  logistic_step u_step (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .start_i (step_start),
    .x_i     (x_q),
    .y_o     (step_y),
    .valid_o (step_valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= WAIT_HI;
      req_q        <= '0;
      req_prev_q   <= '0;
      x_q          <= SEED;
      pio_q        <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      proto_err_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_hi_q    <= 1'b0;
    end else begin
      req_q      <= pio.outputPio;
      req_prev_q <= req_q;
      case (state_q)
        WAIT_HI: begin
          if (have_req) begin
            pend_valid_q <= 1'b0;
            if (req_hi) begin
              state_q <= SEND_HI;
            end else begin
              proto_err_q <= 1'b1;
            end
          end
        end
        SEND_HI: begin
          pio_q   <= {TAG_HI, x_q[31:16]};
          state_q <= WAIT_LO;
          if (new_req && !pend_valid_q) begin
            pend_valid_q <= 1'b1;
            pend_hi_q    <= new_is_hi;
          end
        end
        WAIT_LO: begin
          if (have_req) begin
            pend_valid_q <= 1'b0;
            state_q      <= req_hi ? SEND_HI : SEND_LO;
          end
        end
        SEND_LO: begin
          pio_q        <= {TAG_LO, x_q[15:0]};
          word_count_q <= word_count_q + 10'd1;
          state_q      <= COMPUTE;
          if (new_req && !pend_valid_q) begin
            pend_valid_q <= 1'b1;
            pend_hi_q    <= new_is_hi;
          end
        end
        COMPUTE: begin
          if (new_req && !pend_valid_q) begin
            pend_valid_q <= 1'b1;
            pend_hi_q    <= new_is_hi;
          end
          if (step_valid) begin
            x_q <= step_y;
            if (word_count_q == NUM_W) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_HI;
            end
          end
        end
        DONE: begin
          pend_valid_q <= 1'b0;
        end
        default: begin
          state_q <= WAIT_HI;
        end
      endcase
    end
  end

  assign pio.inputPio = pio_q;
  assign word_count   = word_count_q;
  assign done         = done_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_pio_logistic_sender.sv
// tb/tb_pio_logistic_sender.sv - directed scoreboard bench for pio_logistic_sender
module tb_pio_logistic_sender;
  import pio_sender_pkg::*;

  localparam logic [31:0] SEED_DEF  = 32'h03E4_4970;
  localparam logic [31:0] SEED_HALF = 32'h0800_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pio_logistic_sender_if ifa ();
  pio_logistic_sender_if ifb ();
  pio_logistic_sender_if ifc ();

  logic [9:0] wc_a, wc_b, wc_c;
  logic       done_a, done_b, done_c;
  logic       perr_a, perr_b, perr_c;

  pio_logistic_sender u_a (
    .CLOCK_50(clk), .reset(rst), .pio(ifa),
    .word_count(wc_a), .done(done_a), .proto_err(perr_a)
  );

  pio_logistic_sender #(.SEED(SEED_HALF)) u_b (
    .CLOCK_50(clk), .reset(rst), .pio(ifb),
    .word_count(wc_b), .done(done_b), .proto_err(perr_b)
  );

  pio_logistic_sender #(.NUM_WORDS(4)) u_c (
    .CLOCK_50(clk), .reset(rst), .pio(ifc),
    .word_count(wc_c), .done(done_c), .proto_err(perr_c)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] model_next(logic [31:0] x);
    logic [63:0] a, b, p;
    a = ({32'd0, x} << 2) & 64'h0000_0000_3FFF_FFFF;
    b = {32'd0, ONE_Q28 - x} & 64'h0000_0000_1FFF_FFFF;
    p = a * b;
    return p[59:28];
  endfunction

  function automatic logic [31:0] get_pio(int idx);
    case (idx)
      0:       return ifa.inputPio;
      1:       return ifb.inputPio;
      default: return ifc.inputPio;
    endcase
  endfunction

  task automatic set_req(int idx, logic [31:0] code);
    case (idx)
      0:       ifa.outputPio = code;
      1:       ifb.outputPio = code;
      default: ifc.outputPio = code;
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 32'd0);
    set_req(1, 32'd0);
    set_req(2, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Code captured at edge n; the response must be visible just after edge n+2
  task automatic request(int idx, logic [31:0] code, logic [31:0] exp_word, string tag);
    exp_q.push_back(exp_word);
    @(negedge clk);
    set_req(idx, code);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, get_pio(idx), exp_q.pop_front());
  endtask

  task automatic idle(int idx, int n);
    @(negedge clk);
    set_req(idx, 32'd0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pair(int idx, logic [31:0] x, string tag);
    request(idx, REQ_HI, {TAG_HI, x[31:16]}, {tag, "_hi"});
    request(idx, REQ_LO, {TAG_LO, x[15:0]}, {tag, "_lo"});
    idle(idx, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] last_lo;
    int sends;

    rst = 1'b1;
    ifa.outputPio = '0;
    ifb.outputPio = '0;
    ifc.outputPio = '0;
    do_reset();
    #1;
    chk("rst_pio",   ifa.inputPio, 32'h0);
    chk("rst_wc",    32'(wc_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_perr",  32'(perr_a), 32'd0);
    chk("rst_state", 32'(u_a.state_q), 32'(WAIT_HI));

    request(0, REQ_HI, 32'h0045_03E4, "seed_hi");
    request(0, REQ_LO, 32'h0048_4970, "seed_lo");
    chk("seed_wc", 32'(wc_a), 32'd1);
    idle(0, 4);

    pair(1, 32'h0800_0000, "half_w0");
    pair(1, 32'h1000_0000, "half_w1");
    pair(1, 32'h0000_0000, "half_w2");
    chk("half_wc", 32'(wc_b), 32'd3);

    x = model_next(SEED_DEF);
    exp_q.push_back({TAG_HI, x[31:16]});
    @(negedge clk);
    set_req(0, REQ_HI);
    sends = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (u_a.state_q == SEND_HI) sends++;
    end
    chk("hold_pio", ifa.inputPio, exp_q.pop_front());
    chk("hold_sends", 32'(sends), 32'd1);
    chk("hold_state", 32'(u_a.state_q), 32'(WAIT_LO));
    idle(0, 3);
    request(0, REQ_HI, {TAG_HI, x[31:16]}, "resend_pio");
    chk("resend_state", 32'(u_a.state_q), 32'(WAIT_LO));
    request(0, REQ_LO, {TAG_LO, x[15:0]}, "hi_to_lo");
    chk("hold_wc", 32'(wc_a), 32'd2);
    idle(0, 4);

    do_reset();
    request(0, REQ_LO, 32'h0, "perr_pio");
    chk("perr_flag", 32'(perr_a), 32'd1);
    idle(0, 2);
    request(0, REQ_HI, 32'h0045_03E4, "perr_then_hi");
    request(0, REQ_LO, 32'h0048_4970, "perr_then_lo");
    idle(0, 4);

    do_reset();
    request(0, REQ_LO, 32'h0, "mid_perr_pio");
    idle(0, 2);
    pair(0, SEED_DEF, "mid_w0");
    x = model_next(SEED_DEF);
    request(0, REQ_HI, {TAG_HI, x[31:16]}, "mid_w1_hi");
    request(0, REQ_LO, {TAG_LO, x[15:0]}, "mid_w1_lo");
    chk("mid_in_compute", 32'(u_a.state_q), 32'(COMPUTE));
    rst = 1'b1;
    set_req(0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_wc",   32'(wc_a), 32'd0);
    chk("mid_perr", 32'(perr_a), 32'd0);
    chk("mid_pio",  ifa.inputPio, 32'h0);
    idle(0, 2);
    request(0, REQ_HI, 32'h0045_03E4, "mid_after_hi");
    idle(0, 2);

    do_reset();
    x = SEED_DEF;
    last_lo = '0;
    for (int i = 0; i < 4; i++) begin
      pair(2, x, $sformatf("lim_w%0d", i));
      last_lo = {TAG_LO, x[15:0]};
      x = model_next(x);
      if (i == 2) chk("lim_done_early", 32'(done_c), 32'd0);
    end
    chk("lim_done", 32'(done_c), 32'd1);
    chk("lim_wc", 32'(wc_c), 32'd4);
    for (int i = 0; i < 2; i++) begin
      request(2, REQ_HI, last_lo, $sformatf("lim_frozen_hi%0d", i));
      request(2, REQ_LO, last_lo, $sformatf("lim_frozen_lo%0d", i));
      idle(2, 4);
    end
    chk("lim_wc_final", 32'(wc_c), 32'd4);
    chk("lim_done_final", 32'(done_c), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pio_logistic_sender.md
# pio_logistic_sender

Synthesizable PIO-side transmitter that answers the fill-buffer block's half-word requests. The fill block issues request codes on `outputPio`; this block returns tagged 16-bit halves of a Q4.28 logistic-map sequence on `inputPio`. It replaces the behavioural sender model so the fill/process buffer path can be exercised in hardware without the ARM.

## Interface
- `SEED`, 32'h03E44970, initial x in Q4.28 (0 < x ≤ ONE)
- `NUM_WORDS`, 512, 32-bit words sent before entering DONE
- `CLOCK_50` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `outputPio` input 32: request code from the fill block
- `inputPio` output 32: tagged response word to the fill block
- `word_count` output 10: full words completed (hi and lo both sent)
- `done` output 1: high once NUM_WORDS words are sent; sticky until reset
- `proto_err` output 1: sticky, set on an out-of-order request

## Operation
- Request codes: REQ_HI = 32'h00000006, REQ_LO = 32'h00000003. Any other value is idle.
- Responses: hi = {16'h0045, x[31:16]}, lo = {16'h0048, x[15:0]}.
- Request detection: `outputPio` is registered once (`req_q`). A request is "new" when `req_q` differs from its previous registered value and equals REQ_HI or REQ_LO. A held code triggers exactly one response. 6 changing directly to 3 counts as a new REQ_LO.
- FSM states:
  - WAIT_HI: new REQ_HI → SEND_HI. New REQ_LO → set proto_err, stay.
  - SEND_HI: drive hi word → WAIT_LO.
  - WAIT_LO: new REQ_LO → SEND_LO. New REQ_HI → resend the same hi word, stay.
  - SEND_LO: drive lo word, increment word_count → COMPUTE.
  - COMPUTE: 2 cycles, x ← next(x). Requests arriving here are latched (one-deep) and serviced on return to WAIT_HI. Then → WAIT_HI, or → DONE if word_count == NUM_WORDS.
  - DONE: ignore all requests. `inputPio` holds the last lo word.
- Arithmetic: next(x) = ((4·x) · (ONE − x)) >> 28, with ONE = 32'h10000000.
  - 4·x is 30-bit, ONE − x is 29-bit, the product is a 64-bit unsigned intermediate; the result is truncated to bits [59:28].
  - x > ONE is never produced for legal seeds; if it is, ONE − x wraps mod 2^32 and no guard is applied.
- `inputPio` changes only in SEND_HI/SEND_LO; otherwise it holds its value.

## Timing
- Reset values: inputPio = 0, word_count = 0, done = 0, proto_err = 0, x = SEED, state = WAIT_HI, req_q = 0.
- Latency: a request code present at edge n is registered at n. The response is on `inputPio` after edge n+2, i.e. 2 cycles.
- Next value: ready 2 cycles after SEND_LO. Worst-case hi response after a lo response is therefore 5 cycles. The fill block's request spacing is far larger, so no backpressure is needed.
- `done` rises on the edge leaving the final COMPUTE.
- Reset asserted mid-sequence (any state, including COMPUTE) restores all reset values on the next edge and discards any latched request.

## Structure
- Package `pio_sender_pkg`: REQ_HI, REQ_LO, TAG_HI (16'h0045), TAG_LO (16'h0048), ONE_Q28, and the state enum (WAIT_HI, SEND_HI, WAIT_LO, SEND_LO, COMPUTE, DONE).
- Sub-module `logistic_step`: 2-stage registered multiply.
  - Stage 1: 4·x and ONE − x.
  - Stage 2: product >> 28, `valid` out.
  - Top-level FSM plus request edge detector.

## Test plan
- Default SEED; REQ_HI, then REQ_LO → `inputPio` = 32'h004503E4, then 32'h00484970, each 2 cycles after the request; word_count = 1.
- SEED = 32'h08000000; three hi/lo pairs → words 0x08000000, 0x10000000, 0x00000000.
- REQ_HI held for 100 cycles → exactly one response. Then REQ_HI → 0 → REQ_HI → hi word resent unchanged, state still WAIT_LO.
- REQ_LO first after reset → proto_err = 1, `inputPio` stays 0, a following REQ_HI is answered normally.
- NUM_WORDS = 4, six pairs issued → done = 1 after the 4th lo word, word_count = 4, `inputPio` frozen at the 4th lo word.
- Reset asserted in COMPUTE after word 2 → next REQ_HI returns the SEED hi word, word_count = 0, proto_err = 0.
